decode_3to8_seq: RTL and testbench

//  Sequenced binary-to-one-hot decoder: the output-side counterpart of the 8-to-3 priority encoder.

---
 rtl/decode_3to8_seq_pkg.sv | 19 +
 rtl/decode_3to8_seq_if.sv | 29 ++
 rtl/decode_3to8_seq_code_fifo.sv | 57 +++++
 rtl/decode_3to8_seq.sv | 118 +++++++++++
 tb/tb_decode_3to8_seq.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/decode_3to8_seq_pkg.sv
// Shared types for the sequenced 3-to-8 decoder.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package decode_seq_pkg;

    localparam int W = 3;
    localparam int N = 1 << W;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    typedef struct packed {
        logic         en;
        logic [W-1:0] code;
    } entry_t;

endpackage

// File: rtl/decode_3to8_seq_if.sv
// Producer-side handshake plus presented one-hot word and status.
// Latency: none (wiring only).
// Backpressure: in_ready qualifies in_valid; the output side has no stall.
interface decode_3to8_seq_if
    import decode_seq_pkg::*;
#(
    parameter int DEPTH = 4
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic [W-1:0]             in_code;
    logic                     in_en;
    logic [N-1:0]             y;
    logic                     y_valid;
    logic                     busy;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_code, in_en,
        input  in_ready, y, y_valid, busy, count
    );

    modport slave (
        input  in_valid, in_code, in_en,
        output in_ready, y, y_valid, busy, count
    );

endinterface

// File: rtl/decode_3to8_seq_code_fifo.sv
// Small synchronous FIFO of decoder entries with occupancy count.
// Latency: a pushed entry is visible at dout one edge later.
// Backpressure: push ignored when full, pop ignored when empty; no full pass-through.
module code_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/decode_3to8_seq.sv
// Buffers {en,code} words and presents each as a registered one-hot y for HOLD cycles.
// Latency: word pushed into an idle, empty unit appears on y one edge later.
// Backpressure: in_ready = !full from the registered FIFO count; y side never stalls.
module decode_3to8_seq
    import decode_seq_pkg::*;
#(
    parameter int HOLD  = 4,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    decode_3to8_seq_if.slave   bus
);

    localparam int TW = (HOLD > 1) ? $clog2(HOLD) : 1;

    entry_t                   push_entry;
    entry_t                   head;
    logic [$bits(entry_t)-1:0] head_bits;
    logic                     full;
    logic                     empty;
    logic                     pop;
    logic [$clog2(DEPTH):0]   cnt;

    state_t                   state_q, state_d;
    logic [TW-1:0]            timer_q, timer_d;
    logic [N-1:0]             y_q, y_d;
    logic                     yv_q, yv_d;
    logic [N-1:0]             dec;

    assign push_entry = '{en: bus.in_en, code: bus.in_code};
    assign head       = entry_t'(head_bits);

    code_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_bits),
        .full  (full),
        .empty (empty),
        .count (cnt)
    );

    always_comb begin
        dec = '0;
        for (int i = 0; i < N; i++) begin
            dec[i] = head.en && (head.code == W'(i));
        end
    end

    // Loading from HOLD with timer==0 keeps consecutive words contiguous.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        y_d     = y_q;
        yv_d    = yv_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    y_d     = dec;
                    yv_d    = 1'b1;
                    timer_d = TW'(HOLD - 1);
                    state_d = ST_HOLD;
                end else begin
                    y_d  = '0;
                    yv_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (!empty) begin
                    pop     = 1'b1;
                    y_d     = dec;
                    yv_d    = 1'b1;
                    timer_d = TW'(HOLD - 1);
                end else begin
                    y_d     = '0;
                    yv_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                y_d     = '0;
                yv_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            y_q     <= '0;
            yv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
        end
    end

    assign bus.in_ready = !full;
    assign bus.y        = y_q;
    assign bus.y_valid  = yv_q;
    assign bus.busy     = (state_q == ST_HOLD) || !empty;
    assign bus.count    = cnt;

endmodule

// File: tb/tb_decode_3to8_seq.sv
// Randomized and directed traffic for decode_3to8_seq; a scoreboard queue of accepted
// words is drained by a negedge monitor that checks the y stream, timing and status.
module tb_decode_3to8_seq;
    import decode_seq_pkg::*;

    localparam int HOLD  = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] y;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   run = 0;
    logic [7:0] cur = '0;

    decode_3to8_seq_if #(.DEPTH(DEPTH)) bus ();

    decode_3to8_seq #(.HOLD(HOLD), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bad(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: words accepted at edge e may first appear after edge e+1.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            run = 0;
            chk("rst_y", 32'(bus.y), 32'h0);
            chk("rst_y_valid", 32'(bus.y_valid), 32'h0);
            chk("rst_count", 32'(bus.count), 32'h0);
            chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
            chk("rst_busy", 32'(bus.busy), 32'h0);
        end else begin
            if (bus.y_valid) begin
                if (run == 0) begin
                    if (sb.size() > 0 && sb[0].cyc < cyc) begin
                        cur = sb.pop_front().y;
                    end else begin
                        bad("unexpected_word");
                        cur = bus.y;
                    end
                end
                chk("y_stream", 32'(bus.y), 32'(cur));
                run = (run + 1 == HOLD) ? 0 : run + 1;
            end else begin
                chk("y_idle_zero", 32'(bus.y), 32'h0);
                if (run != 0) bad("short_hold");
                run = 0;
                if (sb.size() > 0 && sb[0].cyc < cyc) bad("idle_gap");
            end
            chk("y_onehot", 32'((bus.y & (bus.y - 8'd1)) == 8'd0), 32'h1);
            chk("count", 32'(bus.count), 32'(sb.size()));
            chk("in_ready", 32'(bus.in_ready), 32'(sb.size() < DEPTH));
            chk("busy", 32'(bus.busy), 32'(bus.y_valid || sb.size() != 0));
        end
    end

    task automatic drive(input logic [2:0] c, input logic e);
        int  t = 0;
        bit  done = 0;
        while (!done) begin
            @(negedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_code  = c;
            bus.in_en    = e;
            if (bus.in_ready) begin
                sb.push_back('{y: (e ? (8'd1 << c) : 8'd0), cyc: cyc + 1});
                done = 1;
            end else if (++t > 50) begin
                bad("push_timeout");
                done = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            bus.in_valid = 1'b0;
            bus.in_code  = 3'($urandom);
            bus.in_en    = 1'($urandom);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk); #1;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_code  = 3'd6;
        bus.in_en    = 1'b1;
        repeat (n) @(negedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((bus.busy || sb.size() != 0) && t < 300) begin
            @(negedge clk); #2;
            t++;
        end
        if (t >= 300) bad("drain_timeout");
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_code  = '0;
        bus.in_en    = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        idle(2);

        drive(3'd5, 1'b1); idle(1); wait_idle();              // single
        drive(3'd0, 1'b1); drive(3'd7, 1'b1); drive(3'd3, 1'b1);
        idle(1); wait_idle();                                  // back-to-back
        for (int c = 1; c <= 7; c++) drive(3'(c), 1'b1);       // overflow
        idle(1); wait_idle();
        drive(3'd2, 1'b0); idle(1); wait_idle();               // blank
        drive(3'd2, 1'b0); drive(3'd6, 1'b1); idle(1); wait_idle();

        for (int c = 0; c < 4; c++) drive(3'(c + 1), 1'b1);    // count=3 mid-hold
        do_reset(1);
        drive(3'd4, 1'b1); idle(1); wait_idle();

        for (int i = 0; i < 90; i++) begin
            if (i == 45) do_reset(2);                          // mid-traffic reset
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
            else drive(3'($urandom), ($urandom_range(0, 4) != 0));
        end
        idle(1);
        wait_idle();
        idle(3);
        chk("final_busy", 32'(bus.busy), 32'h0);
        chk("final_count", 32'(bus.count), 32'h0);
        chk("final_sb_empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
